// File: rtl/datamover_cmd_arbiter.sv
// datamover_cmd_arbiter
//   Shares one datamover command/status channel pair between two requesters.
//   Commands are arbitrated round-robin and forwarded unmodified. Each accepted
//   command records {requester id, tag} in a routing FIFO. Each returned status
//   is steered to the requester at the FIFO head, which is then popped. A sticky
//   flag records any status whose tag differs from the expected one.
//
// Ports
//   clk, aresetn                    clock, asynchronous active-low reset
//   r0_cmd_*, r1_cmd_*              requester command streams (AXI-Stream sink)
//   r0_sts_*, r1_sts_*              requester status streams (AXI-Stream source)
//   m_cmd_*                         command stream to the datamover
//   s_sts_*                         status stream from the datamover
//   err_clr                         synchronous clear of tag_err
//   tag_err                         sticky tag-mismatch flag
//   out0_count, out1_count          outstanding commands per requester
module datamover_cmd_arbiter #(
  parameter int C_CMD_WIDTH = 72,
  parameter int C_STS_WIDTH = 8,
  parameter int C_TAG_LSB   = 64,
  parameter int C_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         r0_cmd_tvalid,
  output logic                         r0_cmd_tready,
  input  logic [C_CMD_WIDTH-1:0]       r0_cmd_tdata,
  input  logic                         r1_cmd_tvalid,
  output logic                         r1_cmd_tready,
  input  logic [C_CMD_WIDTH-1:0]       r1_cmd_tdata,
  output logic                         r0_sts_tvalid,
  input  logic                         r0_sts_tready,
  output logic [C_STS_WIDTH-1:0]       r0_sts_tdata,
  output logic                         r1_sts_tvalid,
  input  logic                         r1_sts_tready,
  output logic [C_STS_WIDTH-1:0]       r1_sts_tdata,
  output logic                         m_cmd_tvalid,
  input  logic                         m_cmd_tready,
  output logic [C_CMD_WIDTH-1:0]       m_cmd_tdata,
  input  logic                         s_sts_tvalid,
  output logic                         s_sts_tready,
  input  logic [C_STS_WIDTH-1:0]       s_sts_tdata,
  input  logic                         err_clr,
  output logic                         tag_err,
  output logic [$clog2(C_DEPTH):0]     out0_count,
  output logic [$clog2(C_DEPTH):0]     out1_count
);

  localparam int PW = $clog2(C_DEPTH);
  localparam int CW = $clog2(C_DEPTH) + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(C_DEPTH);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);
  localparam logic [PW-1:0] LP_PONE = PW'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    r_state;
  logic          r_gnt;       // granted requester id while in GRANT
  logic          r_last;      // last served requester
  logic [4:0]    r_fifo [C_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_cnt0;
  logic [CW-1:0] r_cnt1;
  logic          r_tag_err;

  logic          w_pick;
  logic          w_in_grant;
  logic          w_gvalid;
  logic          w_cmd_hs;
  logic [3:0]    w_cmd_tag;
  logic          w_empty;
  logic          w_head_id;
  logic [3:0]    w_head_tag;
  logic          w_sts_hs;
  logic          w_mismatch;
  logic          w_inc0;
  logic          w_inc1;
  logic          w_dec0;
  logic          w_dec1;

  // Tie goes to whoever was not served last; otherwise the lone requester.
  always_comb begin
    w_pick = 1'b0;
    if (r0_cmd_tvalid && r1_cmd_tvalid) w_pick = ~r_last;
    else                                w_pick = r1_cmd_tvalid;
  end

  // Command path mirrors the granted requester combinationally.
  assign w_in_grant    = (r_state == S_GRANT);
  assign w_gvalid      = r_gnt ? r1_cmd_tvalid : r0_cmd_tvalid;
  assign m_cmd_tvalid  = w_in_grant & w_gvalid;
  assign m_cmd_tdata   = w_in_grant ? (r_gnt ? r1_cmd_tdata : r0_cmd_tdata) : '0;
  assign r0_cmd_tready = w_in_grant & ~r_gnt & m_cmd_tready;
  assign r1_cmd_tready = w_in_grant &  r_gnt & m_cmd_tready;
  assign w_cmd_hs      = m_cmd_tvalid & m_cmd_tready;
  assign w_cmd_tag     = m_cmd_tdata[C_TAG_LSB +: 4];

  // Status path steered by the routing FIFO head.
  assign w_empty       = (r_occ == '0);
  assign w_head_id     = r_fifo[r_rd][4];
  assign w_head_tag    = r_fifo[r_rd][3:0];
  assign r0_sts_tvalid = ~w_empty & ~w_head_id & s_sts_tvalid;
  assign r1_sts_tvalid = ~w_empty &  w_head_id & s_sts_tvalid;
  assign r0_sts_tdata  = r0_sts_tvalid ? s_sts_tdata : '0;
  assign r1_sts_tdata  = r1_sts_tvalid ? s_sts_tdata : '0;
  assign s_sts_tready  = ~w_empty & (w_head_id ? r1_sts_tready : r0_sts_tready);
  assign w_sts_hs      = s_sts_tvalid & s_sts_tready;
  assign w_mismatch    = w_sts_hs & (s_sts_tdata[3:0] != w_head_tag);

  assign w_inc0 = w_cmd_hs & ~r_gnt;
  assign w_inc1 = w_cmd_hs &  r_gnt;
  assign w_dec0 = w_sts_hs & ~w_head_id;
  assign w_dec1 = w_sts_hs &  w_head_id;

  assign tag_err    = r_tag_err;
  assign out0_count = r_cnt0;
  assign out1_count = r_cnt1;

  // Command FSM. Full check uses registered occupancy, so a same-cycle pop
  // does not open the gate; an existing grant is never withdrawn.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r0_cmd_tvalid || r1_cmd_tvalid) && (r_occ != LP_FULL)) begin
            r_state <= S_GRANT;
            r_gnt   <= w_pick;
          end
        end
        default: begin
          if (w_cmd_hs) begin
            r_state <= S_IDLE;
            r_last  <= r_gnt;
          end
        end
      endcase
    end
  end

  // Routing FIFO storage; contents are only meaningful below the occupancy.
  always_ff @(posedge clk) begin
    if (w_cmd_hs) r_fifo[r_wr] <= {r_gnt, w_cmd_tag};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
    end else begin
      if (w_cmd_hs) r_wr <= r_wr + LP_PONE;
      if (w_sts_hs) r_rd <= r_rd + LP_PONE;
      case ({w_cmd_hs, w_sts_hs})
        2'b10:   r_occ <= r_occ + LP_ONE;
        2'b01:   r_occ <= r_occ - LP_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Per-requester outstanding counters.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      case ({w_inc0, w_dec0})
        2'b10:   r_cnt0 <= r_cnt0 + LP_ONE;
        2'b01:   r_cnt0 <= r_cnt0 - LP_ONE;
        default: r_cnt0 <= r_cnt0;
      endcase
      case ({w_inc1, w_dec1})
        2'b10:   r_cnt1 <= r_cnt1 + LP_ONE;
        2'b01:   r_cnt1 <= r_cnt1 - LP_ONE;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

  // Sticky tag error; a new mismatch wins over a simultaneous clear.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tag_err <= 1'b0;
    end else if (w_mismatch) begin
      r_tag_err <= 1'b1;
    end else if (err_clr) begin
      r_tag_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_datamover_cmd_arbiter.sv
// Directed testbench for datamover_cmd_arbiter.
module tb_datamover_cmd_arbiter;

  logic        clk;
  logic        aresetn;
  logic        r0_cmd_tvalid, r0_cmd_tready;
  logic [71:0] r0_cmd_tdata;
  logic        r1_cmd_tvalid, r1_cmd_tready;
  logic [71:0] r1_cmd_tdata;
  logic        r0_sts_tvalid, r0_sts_tready;
  logic [7:0]  r0_sts_tdata;
  logic        r1_sts_tvalid, r1_sts_tready;
  logic [7:0]  r1_sts_tdata;
  logic        m_cmd_tvalid, m_cmd_tready;
  logic [71:0] m_cmd_tdata;
  logic        s_sts_tvalid, s_sts_tready;
  logic [7:0]  s_sts_tdata;
  logic        err_clr;
  logic        tag_err;
  logic [2:0]  out0_count, out1_count;

  int n_tot = 0;
  int n_bad = 0;

  datamover_cmd_arbiter #(
    .C_CMD_WIDTH(72), .C_STS_WIDTH(8), .C_TAG_LSB(64), .C_DEPTH(4)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .r0_cmd_tvalid(r0_cmd_tvalid), .r0_cmd_tready(r0_cmd_tready), .r0_cmd_tdata(r0_cmd_tdata),
    .r1_cmd_tvalid(r1_cmd_tvalid), .r1_cmd_tready(r1_cmd_tready), .r1_cmd_tdata(r1_cmd_tdata),
    .r0_sts_tvalid(r0_sts_tvalid), .r0_sts_tready(r0_sts_tready), .r0_sts_tdata(r0_sts_tdata),
    .r1_sts_tvalid(r1_sts_tvalid), .r1_sts_tready(r1_sts_tready), .r1_sts_tdata(r1_sts_tdata),
    .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready), .m_cmd_tdata(m_cmd_tdata),
    .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready), .s_sts_tdata(s_sts_tdata),
    .err_clr(err_clr), .tag_err(tag_err),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    r0_cmd_tvalid = 1'b0; r1_cmd_tvalid = 1'b0;
    m_cmd_tready  = 1'b0; s_sts_tvalid  = 1'b0;
    r0_sts_tready = 1'b0; r1_sts_tready = 1'b0;
    err_clr       = 1'b0; s_sts_tdata   = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  // Offers one command from requester id and waits (bounded) for its handshake.
  task automatic send_cmd(input int id, input logic [71:0] d);
    bit hs;
    hs = 1'b0;
    @(negedge clk);
    if (id == 0) begin r0_cmd_tvalid = 1'b1; r0_cmd_tdata = d; end
    else         begin r1_cmd_tvalid = 1'b1; r1_cmd_tdata = d; end
    m_cmd_tready = 1'b1;
    for (int k = 0; k < 10 && !hs; k++) begin
      #1;
      hs = (id == 0) ? r0_cmd_tready : r1_cmd_tready;
      @(posedge clk);
    end
    chk("cmd_handshake", 72'(hs), 72'd1);
    @(negedge clk);
    r0_cmd_tvalid = 1'b0; r1_cmd_tvalid = 1'b0; m_cmd_tready = 1'b0;
  endtask

  logic [71:0] d0, d1;
  int          order [4];
  int          g;

  initial begin
    aresetn = 1'b0;
    idle_inputs();
    r0_cmd_tdata = '0; r1_cmd_tdata = '0;
    #1;
    // Reset state
    chk("rst_m_cmd_tvalid", 72'(m_cmd_tvalid), 72'd0);
    chk("rst_s_sts_tready", 72'(s_sts_tready), 72'd0);
    chk("rst_r0_cmd_tready", 72'(r0_cmd_tready), 72'd0);
    chk("rst_tag_err", 72'(tag_err), 72'd0);
    chk("rst_out0", 72'(out0_count), 72'd0);
    chk("rst_out1", 72'(out1_count), 72'd0);
    @(negedge clk);
    aresetn = 1'b1;

    // Single command from r0, tag 3, then matching status 0x83
    d0 = {8'h03, 64'hA5A5_0000_1111_2222};
    @(negedge clk);
    r0_cmd_tvalid = 1'b1; r0_cmd_tdata = d0;
    #1;
    chk("idle_no_valid", 72'(m_cmd_tvalid), 72'd0);
    @(negedge clk);
    #1;
    chk("grant_valid", 72'(m_cmd_tvalid), 72'd1);
    chk("grant_data", m_cmd_tdata, d0);
    chk("r0_ready_no_mready", 72'(r0_cmd_tready), 72'd0);
    m_cmd_tready = 1'b1;
    #1;
    chk("r0_ready", 72'(r0_cmd_tready), 72'd1);
    chk("r1_ready_other", 72'(r1_cmd_tready), 72'd0);
    @(negedge clk);
    r0_cmd_tvalid = 1'b0; m_cmd_tready = 1'b0;
    #1;
    chk("out0_after_cmd", 72'(out0_count), 72'd1);
    chk("idle_after_hs", 72'(m_cmd_tvalid), 72'd0);
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h83; r0_sts_tready = 1'b1;
    #1;
    chk("r0_sts_tvalid", 72'(r0_sts_tvalid), 72'd1);
    chk("r0_sts_tdata", 72'(r0_sts_tdata), 72'h83);
    chk("r1_sts_tvalid_off", 72'(r1_sts_tvalid), 72'd0);
    chk("s_sts_tready", 72'(s_sts_tready), 72'd1);
    @(negedge clk);
    s_sts_tvalid = 1'b0; r0_sts_tready = 1'b0;
    #1;
    chk("out0_after_sts", 72'(out0_count), 72'd0);
    chk("tag_err_clean", 72'(tag_err), 72'd0);
    chk("empty_no_sready", 72'(s_sts_tready), 72'd0);

    // Round-robin with both requesters held valid
    do_reset();
    d0 = {8'h01, 64'h0000_0000_0000_00A0};
    d1 = {8'h02, 64'h0000_0000_0000_00B1};
    r0_cmd_tdata = d0; r1_cmd_tdata = d1;
    r0_cmd_tvalid = 1'b1; r1_cmd_tvalid = 1'b1; m_cmd_tready = 1'b1;
    g = 0;
    for (int c = 0; c < 20 && g < 4; c++) begin
      #1;
      if (m_cmd_tvalid && m_cmd_tready) begin
        order[g] = r1_cmd_tready ? 1 : 0;
        g++;
      end
      @(negedge clk);
    end
    chk("rr_grant_count", 72'(g), 72'd4);
    chk("rr_order0", 72'(order[0]), 72'd0);
    chk("rr_order1", 72'(order[1]), 72'd1);
    chk("rr_order2", 72'(order[2]), 72'd0);
    chk("rr_order3", 72'(order[3]), 72'd1);
    #1;
    chk("rr_out0", 72'(out0_count), 72'd2);
    chk("rr_out1", 72'(out1_count), 72'd2);

    // FIFO full blocks further grants until a status pops
    r0_cmd_tvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("full_blocked", 72'(m_cmd_tvalid), 72'd0);
    end
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h01; r0_sts_tready = 1'b1;
    #1;
    chk("full_pop_route", 72'(r0_sts_tvalid), 72'd1);
    @(negedge clk);
    s_sts_tvalid = 1'b0; r0_sts_tready = 1'b0;
    #1;
    chk("no_grant_pop_cycle", 72'(m_cmd_tvalid), 72'd0);
    @(negedge clk);
    #1;
    chk("grant_after_pop", 72'(m_cmd_tvalid), 72'd1);
    chk("grant_after_pop_r1", 72'(r1_cmd_tready), 72'd1);
    chk("grant_after_pop_data", m_cmd_tdata, d1);
    @(negedge clk);
    r1_cmd_tvalid = 1'b0; m_cmd_tready = 1'b0;
    #1;
    chk("after_pop_out0", 72'(out0_count), 72'd1);
    chk("after_pop_out1", 72'(out1_count), 72'd3);
    chk("after_pop_tag_err", 72'(tag_err), 72'd0);

    // Tag mismatch: r1 sends tag 5, status returns tag 6
    do_reset();
    send_cmd(1, {8'h05, 64'h1234_5678_9ABC_DEF0});
    chk("mm_out1", 72'(out1_count), 72'd1);
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h06; r1_sts_tready = 1'b1;
    #1;
    chk("mm_r1_tvalid", 72'(r1_sts_tvalid), 72'd1);
    chk("mm_r1_tdata", 72'(r1_sts_tdata), 72'h06);
    chk("mm_r0_tvalid", 72'(r0_sts_tvalid), 72'd0);
    chk("mm_r0_tdata_zero", 72'(r0_sts_tdata), 72'd0);
    @(negedge clk);
    s_sts_tvalid = 1'b0; r1_sts_tready = 1'b0;
    #1;
    chk("mm_tag_err_set", 72'(tag_err), 72'd1);
    chk("mm_out1_done", 72'(out1_count), 72'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("mm_tag_err_clr", 72'(tag_err), 72'd0);

    // Status offered with empty FIFO
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h44; r0_sts_tready = 1'b1; r1_sts_tready = 1'b1;
    #1;
    chk("empty_sready", 72'(s_sts_tready), 72'd0);
    chk("empty_r0_tvalid", 72'(r0_sts_tvalid), 72'd0);
    chk("empty_r1_tvalid", 72'(r1_sts_tvalid), 72'd0);
    @(negedge clk);
    s_sts_tvalid = 1'b0; r0_sts_tready = 1'b0; r1_sts_tready = 1'b0;

    // Mismatch and err_clr in the same cycle: set wins
    send_cmd(0, {8'h02, 64'h0});
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h07; r0_sts_tready = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    s_sts_tvalid = 1'b0; r0_sts_tready = 1'b0; err_clr = 1'b0;
    #1;
    chk("set_beats_clr", 72'(tag_err), 72'd1);

    // Reset during GRANT with two outstanding
    do_reset();
    send_cmd(0, {8'h01, 64'h11});
    send_cmd(0, {8'h02, 64'h22});
    chk("pre_rst_out0", 72'(out0_count), 72'd2);
    r1_cmd_tvalid = 1'b1; r1_cmd_tdata = {8'h03, 64'h33};
    @(negedge clk);
    #1;
    chk("pre_rst_grant", 72'(m_cmd_tvalid), 72'd1);
    aresetn = 1'b0; m_cmd_tready = 1'b1;
    #1;
    chk("arst_m_cmd_tvalid", 72'(m_cmd_tvalid), 72'd0);
    chk("arst_r1_cmd_tready", 72'(r1_cmd_tready), 72'd0);
    chk("arst_out0", 72'(out0_count), 72'd0);
    chk("arst_tag_err", 72'(tag_err), 72'd0);
    r1_cmd_tvalid = 1'b0; m_cmd_tready = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    s_sts_tvalid = 1'b1; s_sts_tdata = 8'h01; r0_sts_tready = 1'b1;
    #1;
    chk("post_rst_sready", 72'(s_sts_tready), 72'd0);
    chk("post_rst_r0_tvalid", 72'(r0_sts_tvalid), 72'd0);
    @(negedge clk);
    s_sts_tvalid = 1'b0; r0_sts_tready = 1'b0;
    #1;
    chk("post_rst_out0", 72'(out0_count), 72'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
